// File: rtl/wavelet_filter_bank.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// wavelet_filter_bank
//
// Multi-scale Haar-style wavelet front end. A slow, asynchronous data strobe
// is synchronised into the clk domain. Each accepted rising edge shifts the
// signed sample into a shared tap delay line and, one clk later, starts a
// bank of sequential FIR filters. Filter i has an odd length L_i. Its
// coefficients are +1 on the newer half of its taps, 0 on the centre tap and
// -1 on the older half.
//
// Ports
//   clk         : system clock, all logic on the rising edge
//   i_rst       : asynchronous active-high reset
//   i_value     : signed sample, captured when a strobe edge is accepted
//   i_data_clk  : asynchronous data strobe, a rising edge marks a new sample
//   o_sum       : signed 32-bit result per filter, filter i in [32i+31:32i]
//   o_valid     : one-clk pulse per filter when its o_sum slice updates
//   o_LED2      : heartbeat, MSB of the accepted-sample counter
// ---------------------------------------------------------------------------
module wavelet_filter_bank #(
    parameter int BITS_PER_ELEM = 8,
    parameter int TOTAL_FILTERS = 3,
    parameter int COUNTER_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            i_rst,
    input  logic signed [BITS_PER_ELEM-1:0] i_value,
    input  logic                            i_data_clk,
    output logic [32*TOTAL_FILTERS-1:0]     o_sum,
    output logic [TOTAL_FILTERS-1:0]        o_valid,
    output logic                            o_LED2
);

    // Filter length for scale idx: floor(3 / 0.577472^idx), bumped to the
    // next odd value so every filter has a single centre tap. The quotient is
    // carried in fixed point scaled by 1e6, which keeps the constant
    // evaluation purely integer.
    function automatic int filt_len(input int idx);
        longint scaled;
        int     len;
        scaled = 64'sd3_000_000;
        for (int j = 0; j < idx; j++) begin
            scaled = (scaled * 64'sd1_000_000) / 64'sd577_472;
        end
        len = int'(scaled / 64'sd1_000_000);
        if ((len % 32'sd2) == 32'sd0) begin
            len = len + 32'sd1;
        end
        return len;
    endfunction

    // Lengths grow with scale, so the last filter sets the delay-line depth.
    localparam int TOTAL_TAPS = filt_len(TOTAL_FILTERS - 1);
    localparam int KW         = $clog2(TOTAL_TAPS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } filt_state_e;

    // ------------------------------------------------------------------
    // Strobe capture, delay line and heartbeat counter
    // ------------------------------------------------------------------
    logic                            sync1_q,  sync1_d;
    logic                            sync2_q,  sync2_d;
    logic                            prev_q,   prev_d;
    logic                            accept_q, accept_d;
    logic                            start_q,  start_d;
    logic [COUNTER_WIDTH-1:0]        cnt_q,    cnt_d;
    logic signed [BITS_PER_ELEM-1:0] tap_q [TOTAL_TAPS];
    logic signed [BITS_PER_ELEM-1:0] tap_d [TOTAL_TAPS];

    // Next-state logic for the synchroniser, edge detector, taps and counter.
    always_comb begin
        sync1_d  = i_data_clk;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        // Registered edge detector: one pulse per 0->1 of the synced strobe.
        accept_d = sync2_q & ~prev_q;
        // Filters start one clk after the shift so they see the new taps.
        start_d  = accept_q;

        if (accept_q) begin
            tap_d[0] = i_value;
            for (int k = 1; k < TOTAL_TAPS; k++) begin
                tap_d[k] = tap_q[k-1];
            end
            cnt_d = cnt_q + {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            for (int k = 0; k < TOTAL_TAPS; k++) begin
                tap_d[k] = tap_q[k];
            end
            cnt_d = cnt_q;
        end
    end

    // Front-end registers; everything clears on reset so a strobe already
    // high at release is still seen as a fresh rising edge.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            accept_q <= 1'b0;
            start_q  <= 1'b0;
            cnt_q    <= '0;
            for (int k = 0; k < TOTAL_TAPS; k++) begin
                tap_q[k] <= '0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            accept_q <= accept_d;
            start_q  <= start_d;
            cnt_q    <= cnt_d;
            for (int k = 0; k < TOTAL_TAPS; k++) begin
                tap_q[k] <= tap_d[k];
            end
        end
    end

    assign o_LED2 = cnt_q[COUNTER_WIDTH-1];

    // ------------------------------------------------------------------
    // Filter bank: one sequential multiply-free MAC per scale
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < TOTAL_FILTERS; gi++) begin : g_filt
        localparam int            L      = filt_len(gi);
        localparam logic [KW-1:0] K_LAST = KW'(L - 1);
        localparam logic [KW-1:0] K_CTR  = KW'((L - 1) / 2);

        filt_state_e        state_q, state_d;
        logic [KW-1:0]      k_q,     k_d;
        logic signed [31:0] acc_q,   acc_d;
        logic signed [31:0] sum_q,   sum_d;
        logic               valid_q, valid_d;
        logic signed [31:0] tap_ext_s;
        logic signed [31:0] term_s;

        // Current term: the live tap at index k, sign-extended and weighted.
        always_comb begin
            tap_ext_s = {{(32-BITS_PER_ELEM){tap_q[k_q][BITS_PER_ELEM-1]}}, tap_q[k_q]};
            if (k_q < K_CTR) begin
                term_s = tap_ext_s;
            end else if (k_q == K_CTR) begin
                term_s = 32'sd0;
            end else begin
                term_s = -tap_ext_s;
            end
        end

        // FSM next state. start_q has priority over an in-progress run
        // (abort and restart), but DONE still publishes before restarting.
        always_comb begin
            state_d = state_q;
            k_d     = k_q;
            acc_d   = acc_q;
            sum_d   = sum_q;
            valid_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_q) begin
                        state_d = S_RUN;
                        k_d     = '0;
                        acc_d   = 32'sd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (start_q) begin
                        k_d   = '0;
                        acc_d = 32'sd0;
                    end else begin
                        acc_d = acc_q + term_s;
                        if (k_q == K_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            k_d = k_q + KW'(1'b1);
                        end
                    end
                end
                S_DONE: begin
                    sum_d   = acc_q;
                    valid_d = 1'b1;
                    if (start_q) begin
                        state_d = S_RUN;
                        k_d     = '0;
                        acc_d   = 32'sd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    k_d     = '0;
                    acc_d   = 32'sd0;
                end
            endcase
        end

        // Filter state, accumulator and registered outputs.
        always_ff @(posedge clk or posedge i_rst) begin
            if (i_rst) begin
                state_q <= S_IDLE;
                k_q     <= '0;
                acc_q   <= 32'sd0;
                sum_q   <= 32'sd0;
                valid_q <= 1'b0;
            end else begin
                state_q <= state_d;
                k_q     <= k_d;
                acc_q   <= acc_d;
                sum_q   <= sum_d;
                valid_q <= valid_d;
            end
        end

        assign o_sum[32*gi +: 32] = sum_q;
        assign o_valid[gi]        = valid_q;
    end

endmodule

// File: tb/tb_wavelet_filter_bank.sv
`timescale 1ns/1ps
// Scoreboard bench for wavelet_filter_bank: each strobe pushes hand-computed
// results and arrival cycles per filter; a negedge monitor pops and compares
// whenever the DUT pulses o_valid.
module tb_wavelet_filter_bank;

    localparam int NF = 3;
    localparam int LEN0 = 3;
    localparam int LEN1 = 5;
    localparam int LEN2 = 9;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    logic              clk;
    logic              i_rst;
    logic signed [7:0] i_value;
    logic              i_data_clk;
    logic [32*NF-1:0]  o_sum;
    logic [NF-1:0]     o_valid;
    logic              o_LED2;

    int   cyc;
    int   n_checks;
    int   n_pass;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    wavelet_filter_bank #(
        .BITS_PER_ELEM(8),
        .TOTAL_FILTERS(NF),
        .COUNTER_WIDTH(4)
    ) dut (
        .clk       (clk),
        .i_rst     (i_rst),
        .i_value   (i_value),
        .i_data_clk(i_data_clk),
        .o_sum     (o_sum),
        .o_valid   (o_valid),
        .o_LED2    (o_LED2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int req);
        n_checks++;
        if (got == req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // Pop one expectation for filter idx and compare value and arrival cycle.
    task automatic mon_one(input int idx, input int got, input int now);
        exp_t e;
        bit   have;
        have = 1'b0;
        case (idx)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_checks++;
            $display("FAIL unexpected_valid f%0d: got sum %0d at cycle %0d, required no output", idx, got, now);
        end else begin
            check($sformatf("sum_f%0d", idx), got, e.val);
            check($sformatf("latency_f%0d", idx), now, e.cyc);
        end
    endtask

    // Monitor: runs independently of stimulus.
    always @(negedge clk) begin
        if (!i_rst) begin
            for (int i = 0; i < NF; i++) begin
                if (o_valid[i]) begin
                    mon_one(i, $signed(o_sum[32*i +: 32]), cyc);
                end
            end
        end
    end

    // One strobe: rise at a negedge, so the next posedge (edge n = cyc+1)
    // samples it; filter i then presents its result at edge n+5+L_i.
    task automatic send(input logic signed [7:0] v, input int e0, input int e1, input int e2,
                        input bit p01, input bit p2, input int hi, input int gap);
        int c;
        @(negedge clk);
        i_value    = v;
        i_data_clk = 1'b1;
        c = cyc;
        if (p01) begin
            q0.push_back('{val: e0, cyc: c + 6 + LEN0});
            q1.push_back('{val: e1, cyc: c + 6 + LEN1});
        end
        if (p2) begin
            q2.push_back('{val: e2, cyc: c + 6 + LEN2});
        end
        repeat (hi) @(negedge clk);
        i_data_clk = 1'b0;
        repeat (gap - hi) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sum0"}, $signed(o_sum[31:0]), 0);
        check({tag, "_sum1"}, $signed(o_sum[63:32]), 0);
        check({tag, "_sum2"}, $signed(o_sum[95:64]), 0);
        check({tag, "_valid"}, int'(o_valid), 0);
        check({tag, "_led"}, int'(o_LED2), 0);
    endtask

    int imp0 [10] = '{10, 0, -10, 0, 0, 0, 0, 0, 0, 0};
    int imp1 [10] = '{10, 10, 0, -10, -10, 0, 0, 0, 0, 0};
    int imp2 [10] = '{10, 10, 10, 10, 0, -10, -10, -10, -10, 0};
    int neg0 [9]  = '{-128, -128, 0, 0, 0, 0, 0, 0, 0};
    int neg1 [9]  = '{-128, -256, -256, -128, 0, 0, 0, 0, 0};
    int neg2 [9]  = '{-128, -256, -384, -512, -512, -384, -256, -128, 0};
    int ramp0 [9] = '{129, 130, 2, 2, 2, 2, 2, 2, 2};
    int ramp1 [9] = '{129, 259, 261, 134, 6, 6, 6, 6, 6};
    int ramp2 [9] = '{129, 259, 390, 522, 526, 401, 275, 148, 20};

    initial begin
        cyc        = 0;
        n_checks   = 0;
        n_pass     = 0;
        i_rst      = 1'b1;
        i_value    = 8'sd0;
        i_data_clk = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        i_rst = 1'b0;
        repeat (2) @(negedge clk);

        // Strobe then reset before any filter finishes: result discarded.
        send(8'sd55, 0, 0, 0, 1'b0, 1'b0, 3, 6);
        i_rst = 1'b1;
        #1;
        check_idle("midreset");
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        repeat (2) @(negedge clk);

        // Impulse 10 followed by zeros.
        for (int s = 0; s < 10; s++) begin
            send((s == 0) ? 8'sd10 : 8'sd0, imp0[s], imp1[s], imp2[s], 1'b1, 1'b1, 4, 16);
        end
        // Nine samples of -128.
        for (int s = 0; s < 9; s++) begin
            send(-8'sd128, neg0[s], neg1[s], neg2[s], 1'b1, 1'b1, 4, 16);
        end
        // Ramp 1..9 on top of the -128 history.
        for (int s = 0; s < 9; s++) begin
            send(8'(s + 1), ramp0[s], ramp1[s], ramp2[s], 1'b1, 1'b1, 4, 16);
        end
        // Second strobe 6 clks after the first: filter 2 restarts silently.
        send(8'sd20, 12, 16, 0, 1'b1, 1'b0, 3, 6);
        send(-8'sd30, -39, -25, -11, 1'b1, 1'b1, 3, 16);

        // Heartbeat from a clean counter.
        i_rst = 1'b1;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 1; s <= 16; s++) begin
            send(8'sd0, 0, 0, 0, 1'b1, 1'b1, 4, 16);
            check($sformatf("led_after_%0d", s), int'(o_LED2), ((s % 16) >= 8) ? 1 : 0);
        end

        repeat (20) @(negedge clk);
        check("pending_f0", q0.size(), 0);
        check("pending_f1", q1.size(), 0);
        check("pending_f2", q2.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wavelet_filter_bank.md
# wavelet_filter_bank

Multi-scale wavelet front end. It samples a signed input stream on rising edges of a slow data strobe and shifts each sample into a shared tap delay line. After every new sample it runs a bank of Haar-style FIR filters of increasing length (one per scale) over the newest taps. It sits between the sample source and downstream feature/threshold logic, and drives a heartbeat LED.

## Interface
- BITS_PER_ELEM, 8, width of one signed sample/tap.
- TOTAL_FILTERS, 3, number of filter scales.
- COUNTER_WIDTH, 4, width of the sample heartbeat counter.
- Derived: L_i = floor(3 / 0.577472^i), plus 1 if even, for i = 0..TOTAL_FILTERS-1. Default lengths are 3, 5, 9. TOTAL_TAPS = max L_i (9).
- clk, input, 1, system clock; all logic is on its rising edge.
- i_rst, input, 1, asynchronous active-high reset.
- i_value, input, BITS_PER_ELEM, signed sample, sampled when a data-strobe edge is accepted.
- i_data_clk, input, 1, asynchronous data strobe; a rising edge means a new sample.
- o_sum, output, 32*TOTAL_FILTERS, signed results; filter i occupies bits [32i+31:32i].
- o_valid, output, TOTAL_FILTERS, 1-clk pulse per filter when its o_sum slice updates.
- o_LED2, output, 1, heartbeat: MSB of the sample counter.

## Operation
- **Strobe capture:**
  - i_data_clk passes through a 2-FF synchronizer, then a registered edge detector (prev vs. sync).
  - A 0→1 transition produces one accept pulse.
- **Shift on accept:**
  - tap[0] <= i_value.
  - tap[k] <= tap[k-1] for k = 1..TOTAL_TAPS-1.
  - The oldest tap is dropped.
  - The sample counter increments and wraps modulo 2^COUNTER_WIDTH.
- **Start pulse:** start_calc pulses high one clk after the shift, and is shared by all filters.
- **Filter i:**
  - Uses tap[0..L_i-1], with tap[0] the newest sample. Centre index c = (L_i-1)/2.
  - Coefficients: +1 for k < c, 0 for k = c, -1 for k > c.
  - Result: o_sum_i = Σ_{k<c} tap[k] − Σ_{k>c} tap[k].
  - Taps are sign-extended to 32 bits before accumulation; no saturation is needed.
- **Filter FSM (per filter):**
  - IDLE --start_calc--> RUN. The accumulator is cleared and index k = 0.
  - RUN adds coef[k]*tap[k] each clk, with k = 0..L_i-1.
  - After the k = L_i-1 term, the FSM goes to DONE.
  - DONE writes the accumulator to o_sum_i, pulses o_valid[i] for one clk, and returns to IDLE.
- **Tap stability:** taps are read live while RUN is active, so a shift during RUN corrupts that result. See the restart rule under Timing.
- **Output hold:** o_sum holds its last value between updates.

## Timing
- **Latency:** an i_data_clk rise sampled at clk edge n gives:
  - sync stage 1 at n, sync stage 2 at n+1, accept pulse at n+2;
  - taps shifted at n+3, start_calc high during cycle n+3→n+4;
  - o_sum_i / o_valid[i] after L_i+1 further clks.
  - Default: filter 0 at n+8, filter 1 at n+10, filter 2 at n+14.
- **Restart rule:** if start_calc arrives while a filter is in RUN, that filter aborts, clears its accumulator, and restarts. No o_valid is issued for the aborted run.
- **Strobe spacing:**
  - i_data_clk high and low each ≥ 2 clk periods.
  - Samples spaced ≥ TOTAL_TAPS+5 clk guarantee every filter completes.
- **Reset (asynchronous):**
  - Zeroed: taps, synchronizer/edge regs, counter, o_LED2, all FSMs (IDLE), o_sum, o_valid.
  - An i_data_clk already high at reset release is accepted as a rising edge after 3 clks.
- **Reset mid-computation:** the computation is discarded; o_sum reads 0.
- **Simultaneous events:** a DONE in the same cycle as start_calc still writes o_sum and pulses o_valid, then the filter enters RUN.
- **Heartbeat:** with COUNTER_WIDTH = 4, o_LED2 rises after 8 accepted samples and toggles every 8 thereafter.

## Test plan
- Reset mid-stream with i_data_clk low → all o_sum = 0, o_valid = 0, o_LED2 = 0. The first strobe after release gives o_valid[0] exactly 8 clks after the rising edge is sampled.
- Impulse 10 followed by zeros (one strobe each):
  - filter 0 (L=3) outputs +10, 0, −10, 0;
  - filter 2 (L=9) outputs +10 for samples 1–4, 0 at sample 5, −10 for samples 6–9, then 0.
- Nine samples of −128 → filter 0 = 0, filter 1 = 0, filter 2 = 0, with no overflow.
- Ramp 1,2,…,9 (newest 9) → filter 0 = 9−7 = 2, filter 1 = (9+8)−(6+5) = 6, filter 2 = (9+8+7+6)−(4+3+2+1) = 20.
- Second strobe 6 clks after the first → filter 2 aborts with no o_valid for the first run; the restarted result reflects both samples.
- 16 strobes → o_LED2 rises at the 8th accept, falls at the 16th; counter wraps to 0.
